// File: rtl/home_pkg.sv
// Shared types and constants for the home automation front end: presence
// debounce states, hour encoding, and the day/night decode used on reset and on update.
package home_pkg;

    localparam int HOURS_PER_DAY = 24;
    localparam int HOUR_W        = 5;

    typedef enum logic [1:0] {
        ABSENT    = 2'd0,
        ARMING    = 2'd1,
        PRESENT   = 2'd2,
        RELEASING = 2'd3
    } presence_state_t;

    // Day is the half-open window [dayStart, nightStart).
    function automatic logic isDayHour(
        input logic [HOUR_W-1:0] h,
        input int                dayStart,
        input int                nightStart
    );
        int hv;
        hv = int'(h);
        return (hv >= dayStart) && (hv < nightStart);
    endfunction

endpackage

// File: rtl/occupancy_sensor_frontend_if.sv
// Bundle of the front end's sensor, strobe and status signals.
// The controller side (master) drives the inputs; the front end (slave) drives the status bits.
interface occupancy_sensor_frontend_if;
    import home_pkg::*;

    logic              tick;
    logic              pc_activity_raw;
    logic              pir_raw;
    logic              hour_load;
    logic [HOUR_W-1:0] hour_in;
    logic              profile_load;
    logic              profile_in;
    logic              time_of_day;
    logic              usage_profile;
    logic              computer_inactive;
    logic              presence_detected;
    logic [HOUR_W-1:0] hour;

    modport master (
        output tick, pc_activity_raw, pir_raw, hour_load, hour_in, profile_load, profile_in,
        input  time_of_day, usage_profile, computer_inactive, presence_detected, hour
    );

    modport slave (
        input  tick, pc_activity_raw, pir_raw, hour_load, hour_in, profile_load, profile_in,
        output time_of_day, usage_profile, computer_inactive, presence_detected, hour
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// It clears to zero on reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/occupancy_sensor_frontend.sv
// Conditions raw occupancy inputs into registered status bits: the idle timer,
// the presence debounce, the hour-of-day counter with day/night decode, and the usage profile.
module occupancy_sensor_frontend
    import home_pkg::*;
#(
    parameter int IDLE_TIMEOUT     = 600,
    parameter int DEBOUNCE_TICKS   = 3,
    parameter int TICKS_PER_HOUR   = 3600,
    parameter int DAY_START_HOUR   = 7,
    parameter int NIGHT_START_HOUR = 22,
    parameter int RESET_HOUR       = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    occupancy_sensor_frontend_if.slave  bus
);

    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam int STAB_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam int TICK_W = $clog2(TICKS_PER_HOUR + 1);

    localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(IDLE_TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [STAB_W-1:0] STAB_ONE   = STAB_W'(1);
    localparam logic [STAB_W-1:0] STAB_LAST  = STAB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS_PER_HOUR - 1);
    localparam logic [HOUR_W-1:0] HOUR_LAST  = HOUR_W'(HOURS_PER_DAY - 1);
    localparam logic [HOUR_W-1:0] HOUR_LIMIT = HOUR_W'(HOURS_PER_DAY);
    localparam logic [HOUR_W-1:0] HOUR_RST   = HOUR_W'(RESET_HOUR);

    logic w_pcSync;
    logic w_pirSync;
    logic w_actPulse;
    logic r_pcPrev;

    logic [IDLE_W-1:0] r_idleCnt;
    logic              r_inactive;

    presence_state_t   r_state;
    presence_state_t   w_stateNext;
    logic [STAB_W-1:0] r_stabCnt;
    logic [STAB_W-1:0] w_stabNext;
    logic              r_presence;
    logic              w_presenceNext;

    logic [TICK_W-1:0] r_tickCnt;
    logic [TICK_W-1:0] w_tickNext;
    logic [HOUR_W-1:0] r_hour;
    logic [HOUR_W-1:0] w_hourNext;
    logic              w_hourLoadOk;
    logic              r_timeOfDay;
    logic              r_profile;

    sync_2ff #(.WIDTH(1)) u_syncPc (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.pc_activity_raw),
        .o_sync  (w_pcSync)
    );

    sync_2ff #(.WIDTH(1)) u_syncPir (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.pir_raw),
        .o_sync  (w_pirSync)
    );

    // Only rising edges of activity restart the idle timer, never a held level.
    assign w_actPulse = w_pcSync & ~r_pcPrev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcPrev   <= 1'b0;
            r_idleCnt  <= '0;
            r_inactive <= 1'b0;
        end else begin
            r_pcPrev <= w_pcSync;
            if (w_actPulse) begin
                r_idleCnt  <= '0;
                r_inactive <= 1'b0;
            end else if (bus.tick && (r_idleCnt < IDLE_MAX)) begin
                r_idleCnt <= r_idleCnt + 1'b1;
                if (r_idleCnt == IDLE_LAST) begin
                    r_inactive <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ABSENT;
            r_stabCnt  <= '0;
            r_presence <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_stabCnt  <= w_stabNext;
            r_presence <= w_presenceNext;
        end
    end

    // Debounce: a PIR level must hold for DEBOUNCE_TICKS consecutive ticks to flip presence.
    always_comb begin
        w_stateNext = r_state;
        w_stabNext  = r_stabCnt;
        if (bus.tick) begin
            case (r_state)
                ABSENT: begin
                    if (w_pirSync) begin
                        if (DEBOUNCE_TICKS == 1) begin
                            w_stateNext = PRESENT;
                            w_stabNext  = '0;
                        end else begin
                            w_stateNext = ARMING;
                            w_stabNext  = STAB_ONE;
                        end
                    end
                end
                ARMING: begin
                    if (!w_pirSync) begin
                        w_stateNext = ABSENT;
                        w_stabNext  = '0;
                    end else if (r_stabCnt == STAB_LAST) begin
                        w_stateNext = PRESENT;
                        w_stabNext  = '0;
                    end else begin
                        w_stabNext = r_stabCnt + 1'b1;
                    end
                end
                PRESENT: begin
                    if (!w_pirSync) begin
                        if (DEBOUNCE_TICKS == 1) begin
                            w_stateNext = ABSENT;
                            w_stabNext  = '0;
                        end else begin
                            w_stateNext = RELEASING;
                            w_stabNext  = STAB_ONE;
                        end
                    end
                end
                RELEASING: begin
                    if (w_pirSync) begin
                        w_stateNext = PRESENT;
                        w_stabNext  = '0;
                    end else if (r_stabCnt == STAB_LAST) begin
                        w_stateNext = ABSENT;
                        w_stabNext  = '0;
                    end else begin
                        w_stabNext = r_stabCnt + 1'b1;
                    end
                end
                default: begin
                    w_stateNext = ABSENT;
                    w_stabNext  = '0;
                end
            endcase
        end
        w_presenceNext = (w_stateNext == PRESENT) || (w_stateNext == RELEASING);
    end

    assign w_hourLoadOk = bus.hour_load && (bus.hour_in < HOUR_LIMIT);

    // A valid hour load beats a same-cycle tick or wrap; an out-of-range load is ignored.
    always_comb begin
        w_hourNext = r_hour;
        w_tickNext = r_tickCnt;
        if (w_hourLoadOk) begin
            w_hourNext = bus.hour_in;
            w_tickNext = '0;
        end else if (bus.tick) begin
            if (r_tickCnt == TICK_LAST) begin
                w_tickNext = '0;
                w_hourNext = (r_hour == HOUR_LAST) ? '0 : r_hour + 1'b1;
            end else begin
                w_tickNext = r_tickCnt + 1'b1;
            end
        end
    end

    // time_of_day decodes the next hour so it moves in the same cycle as hour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tickCnt   <= '0;
            r_hour      <= HOUR_RST;
            r_timeOfDay <= isDayHour(HOUR_RST, DAY_START_HOUR, NIGHT_START_HOUR);
            r_profile   <= 1'b0;
        end else begin
            r_tickCnt   <= w_tickNext;
            r_hour      <= w_hourNext;
            r_timeOfDay <= isDayHour(w_hourNext, DAY_START_HOUR, NIGHT_START_HOUR);
            if (bus.profile_load) begin
                r_profile <= bus.profile_in;
            end
        end
    end

    assign bus.time_of_day       = r_timeOfDay;
    assign bus.usage_profile     = r_profile;
    assign bus.computer_inactive = r_inactive;
    assign bus.presence_detected = r_presence;
    assign bus.hour              = r_hour;

endmodule

// File: tb/tb_occupancy_sensor_frontend.sv
// Self-checking bench for occupancy_sensor_frontend: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural model of the status outputs.
module tb_occupancy_sensor_frontend;
    import home_pkg::*;

    localparam int IT    = 4;
    localparam int DB    = 3;
    localparam int TPH   = 2;
    localparam int DAY   = 7;
    localparam int NIGHT = 22;
    localparam int RH    = 0;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    occupancy_sensor_frontend_if bus ();

    occupancy_sensor_frontend #(
        .IDLE_TIMEOUT     (IT),
        .DEBOUNCE_TICKS   (DB),
        .TICKS_PER_HOUR   (TPH),
        .DAY_START_HOUR   (DAY),
        .NIGHT_START_HOUR (NIGHT),
        .RESET_HOUR       (RH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    bit sTick, sPc, sPir, sHl, sPl, sPin;
    int sHin;

    int mIdle, mRun, mHour, mTickCnt;
    bit mInactive, mPresence, mProfile;
    bit pc1, pc2, pc3, pir1, pir2;

    function automatic int dayOf(input int h);
        return ((h >= DAY) && (h < NIGHT)) ? 1 : 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mIdle = 0; mInactive = 0;
        mPresence = 0; mRun = 0;
        mHour = RH; mTickCnt = 0;
        mProfile = 0;
        pc1 = 0; pc2 = 0; pc3 = 0;
        pir1 = 0; pir2 = 0;
    endtask

    // One clock of the spec's rules; raw inputs reach the logic two edges after they are sampled.
    task automatic modelStep();
        bit act;
        bit pirS;
        act  = pc2 && !pc3;
        pirS = pir2;
        if (act) begin
            mIdle = 0;
            mInactive = 0;
        end else if (sTick && mIdle < IT) begin
            mIdle++;
            if (mIdle == IT) mInactive = 1;
        end
        if (sTick) begin
            if (pirS != mPresence) begin
                mRun++;
                if (mRun == DB) begin
                    mPresence = !mPresence;
                    mRun = 0;
                end
            end else begin
                mRun = 0;
            end
        end
        if (sHl && sHin <= 23) begin
            mHour = sHin;
            mTickCnt = 0;
        end else if (sTick) begin
            if (mTickCnt == TPH - 1) begin
                mTickCnt = 0;
                mHour = (mHour + 1) % HOURS_PER_DAY;
            end else begin
                mTickCnt++;
            end
        end
        if (sPl) mProfile = sPin;
        pc3 = pc2; pc2 = pc1; pc1 = sPc;
        pir2 = pir1; pir1 = sPir;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".hour"}, 32'(bus.hour), 32'(mHour));
        checkOutput({tag, ".tod"}, 32'(bus.time_of_day), 32'(dayOf(mHour)));
        checkOutput({tag, ".profile"}, 32'(bus.usage_profile), 32'(mProfile));
        checkOutput({tag, ".inactive"}, 32'(bus.computer_inactive), 32'(mInactive));
        checkOutput({tag, ".presence"}, 32'(bus.presence_detected), 32'(mPresence));
    endtask

    task automatic applyStimulus(input string tag);
        bus.tick            = sTick;
        bus.pc_activity_raw = sPc;
        bus.pir_raw         = sPir;
        bus.hour_load       = sHl;
        bus.hour_in         = 5'(sHin);
        bus.profile_load    = sPl;
        bus.profile_in      = sPin;
        if (rst) modelReset();
        else     modelStep();
        @(posedge clk);
        #1;
        checkAll(tag);
        sTick = 0; sHl = 0; sPl = 0;
    endtask

    task automatic idleCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(tag);
    endtask

    task automatic tickCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            sTick = 1;
            applyStimulus(tag);
        end
    endtask

    initial begin
        sTick = 0; sPc = 0; sPir = 0; sHl = 0; sHin = 0; sPl = 0; sPin = 0;
        bus.tick = 0; bus.pc_activity_raw = 0; bus.pir_raw = 0; bus.hour_load = 0;
        bus.hour_in = '0; bus.profile_load = 0; bus.profile_in = 0;
        rst = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        checkOutput("reset.hourConst", 32'(bus.hour), 32'(RH));
        rst = 1'b0;

        // Idle timer: activity edge, four ticks to timeout, then an edge landing on a tick.
        sPc = 1;
        idleCycles(3, "idle.edge");
        tickCycles(IT, "idle.count");
        checkOutput("idle.timeout", 32'(bus.computer_inactive), 32'd1);
        sPc = 0;
        idleCycles(3, "idle.low");
        sPc = 1;
        idleCycles(2, "idle.rise");
        tickCycles(1, "idle.actWithTick");
        checkOutput("idle.actWins", 32'(bus.computer_inactive), 32'd0);
        tickCycles(IT - 1, "idle.recount");
        checkOutput("idle.notYet", 32'(bus.computer_inactive), 32'd0);
        tickCycles(1, "idle.recount");
        checkOutput("idle.timeout2", 32'(bus.computer_inactive), 32'd1);

        // Debounce: short pulse ignored, full pulse accepted, short dropout ignored.
        sPir = 1;
        idleCycles(2, "pir.sync");
        tickCycles(DB - 1, "pir.short");
        sPir = 0;
        idleCycles(2, "pir.sync");
        tickCycles(1, "pir.short");
        checkOutput("pir.shortIgnored", 32'(bus.presence_detected), 32'd0);
        sPir = 1;
        idleCycles(2, "pir.sync");
        tickCycles(DB - 1, "pir.arm");
        checkOutput("pir.notYet", 32'(bus.presence_detected), 32'd0);
        tickCycles(1, "pir.arm");
        checkOutput("pir.present", 32'(bus.presence_detected), 32'd1);
        sPir = 0;
        idleCycles(2, "pir.sync");
        tickCycles(DB - 1, "pir.release");
        sPir = 1;
        idleCycles(2, "pir.sync");
        tickCycles(DB + 1, "pir.hold");
        checkOutput("pir.dropoutIgnored", 32'(bus.presence_detected), 32'd1);

        // Hour counter: load, wrap at night start and midnight, bad load, load beating a wrap.
        sHl = 1; sHin = 21;
        applyStimulus("hour.load21");
        checkOutput("hour.is21", 32'(bus.hour), 32'd21);
        checkOutput("hour.day21", 32'(bus.time_of_day), 32'd1);
        tickCycles(TPH, "hour.to22");
        checkOutput("hour.is22", 32'(bus.hour), 32'd22);
        checkOutput("hour.night22", 32'(bus.time_of_day), 32'd0);
        tickCycles(2 * TPH, "hour.toMidnight");
        checkOutput("hour.wrap0", 32'(bus.hour), 32'd0);
        sHl = 1; sHin = 25;
        applyStimulus("hour.load25");
        checkOutput("hour.badLoad", 32'(bus.hour), 32'd0);
        tickCycles(1, "hour.half");
        sHl = 1; sHin = 6; sTick = 1;
        applyStimulus("hour.loadOnWrap");
        checkOutput("hour.is6", 32'(bus.hour), 32'd6);
        checkOutput("hour.night6", 32'(bus.time_of_day), 32'd0);
        tickCycles(TPH - 1, "hour.after6");
        checkOutput("hour.still6", 32'(bus.hour), 32'd6);
        tickCycles(1, "hour.to7");
        checkOutput("hour.is7", 32'(bus.hour), 32'd7);
        checkOutput("hour.day7", 32'(bus.time_of_day), 32'd1);

        // Profile: loaded once, then must survive ticks and activity edges.
        sPl = 1; sPin = 1;
        applyStimulus("profile.load");
        checkOutput("profile.set", 32'(bus.usage_profile), 32'd1);
        for (int i = 0; i < 10; i++) begin
            sPc = ~sPc;
            tickCycles(1, "profile.hold");
        end
        checkOutput("profile.held", 32'(bus.usage_profile), 32'd1);

        // Asynchronous reset between clock edges.
        sHl = 1; sHin = 13;
        applyStimulus("arst.load13");
        checkOutput("arst.pre.hour", 32'(bus.hour), 32'd13);
        checkOutput("arst.pre.presence", 32'(bus.presence_detected), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst.hour", 32'(bus.hour), 32'(RH));
        checkOutput("arst.tod", 32'(bus.time_of_day), 32'd0);
        checkOutput("arst.presence", 32'(bus.presence_detected), 32'd0);
        checkOutput("arst.profile", 32'(bus.usage_profile), 32'd0);
        checkOutput("arst.inactive", 32'(bus.computer_inactive), 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            sTick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0)  sPc  = ~sPc;
            if ($urandom_range(0, 11) == 0) sPir = ~sPir;
            if ($urandom_range(0, 29) == 0) begin
                sHl  = 1;
                sHin = int'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 39) == 0) begin
                sPl  = 1;
                sPin = bit'($urandom_range(0, 1));
            end
            rst = ($urandom_range(0, 299) == 0);
            applyStimulus("rand");
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
